// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (imem/dmem) to one-port memory arbiter; define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking
package simple_processor_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module mem_arbiter #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [1:0]            grant_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;
  state_t                  state_q, state_d;
  logic                    req_d, we_d, start, pick_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  assign start = (state_q == IDLE) & (imem_req_i | dmem_req_i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  assign pick_d = dmem_req_i & (~imem_req_i | ~last_q);
  // Remember who won the latest grant (1 = data) so the other side wins the next tie
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) last_q <= 1'b0;
    else if (start) last_q <= pick_d;
`else
  assign pick_d = dmem_req_i;
`endif
  // Grant the winner from IDLE, hold the command until the memory acks, then return to IDLE
  always_comb begin
    state_d = state_q;
    req_d   = mem_req_o;
    we_d    = mem_we_o;
    addr_d  = mem_addr_o;
    wdata_d = mem_wdata_o;
    if (start) begin
      state_d = pick_d ? GNT_D : GNT_I;
      req_d   = 1'b1;
      we_d    = pick_d & dmem_we_i;
      addr_d  = pick_d ? dmem_addr_i : imem_addr_i;
      wdata_d = pick_d ? dmem_wdata_i : '0;
    end else if (state_q != IDLE && mem_ack_i) begin
      state_d = IDLE;
      req_d   = 1'b0;
      we_d    = 1'b0;
    end
  end
  // State and registered memory-side command
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state_q     <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_o   <= req_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
    end
  assign imem_ack_o   = (state_q == GNT_I) & mem_ack_i;
  assign dmem_ack_o   = (state_q == GNT_D) & mem_ack_i;
  assign imem_rdata_o = imem_ack_o ? mem_rdata_i : '0;
  assign dmem_rdata_o = dmem_ack_o ? mem_rdata_i : '0;
  assign grant_o      = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level owner model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          imem_req_i, dmem_req_i, dmem_we_i, mem_ack_i;
  logic [AW-1:0] imem_addr_i, dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i, mem_rdata_i;
  logic [DW-1:0] imem_rdata_o, dmem_rdata_o, mem_wdata_o;
  logic          imem_ack_o, dmem_ack_o, mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    grant_o;
  int            n_chk = 0;
  int            n_pass = 0;
  int            owner = 0;
  bit            last_d = 1'b0;
  bit            e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  bit            i_pend = 1'b0;
  bit            d_pend = 1'b0;
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_rdata_o(imem_rdata_o), .imem_ack_o(imem_ack_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o), .dmem_ack_o(dmem_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .grant_o(grant_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_outputs();
    bit ia, da;
    ia = (owner == 1) && mem_ack_i;
    da = (owner == 2) && mem_ack_i;
    chk("grant", grant_o, owner);
    chk("mem_req", mem_req_o, owner != 0);
    chk("mem_we", mem_we_o, (owner != 0) && e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("imem_ack", imem_ack_o, ia);
    chk("dmem_ack", dmem_ack_o, da);
    chk("imem_rdata", imem_rdata_o, ia ? mem_rdata_i : '0);
    chk("dmem_rdata", dmem_rdata_o, da ? mem_rdata_i : '0);
  endtask
  task automatic model_reset();
    owner = 0; last_d = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    i_pend = 1'b0; d_pend = 1'b0;
  endtask
  task automatic step(input int pi, input int pd, input int pa, input bit drop);
    bit win_d;
    @(negedge clk_i);
    if (!i_pend && $urandom_range(99) < pi) begin i_pend = 1'b1; imem_addr_i = $urandom; end
    if (!d_pend && $urandom_range(99) < pd) begin
      d_pend = 1'b1; dmem_addr_i = $urandom; dmem_wdata_i = $urandom; dmem_we_i = $urandom_range(1);
    end
    if (drop && i_pend && $urandom_range(99) == 0) i_pend = 1'b0;
    if (drop && d_pend && $urandom_range(99) == 0) d_pend = 1'b0;
    imem_req_i  = i_pend;
    dmem_req_i  = d_pend;
    mem_ack_i   = $urandom_range(99) < ((owner != 0) ? pa : 10);
    mem_rdata_i = $urandom;
    #1 check_outputs();
    @(posedge clk_i);
    if (owner == 0) begin
      if (imem_req_i || dmem_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_d = dmem_req_i && (!imem_req_i || !last_d);
`else
        win_d = dmem_req_i;
`endif
        last_d  = win_d;
        owner   = win_d ? 2 : 1;
        e_we    = win_d && dmem_we_i;
        e_addr  = win_d ? dmem_addr_i : imem_addr_i;
        e_wdata = win_d ? dmem_wdata_i : '0;
      end
    end else if (mem_ack_i) begin
      if (owner == 1) i_pend = 1'b0;
      else d_pend = 1'b0;
      owner = 0;
      e_we  = 1'b0;
    end
  endtask
  initial begin
    int n;
    arst_ni = 1'b0;
    imem_req_i = 1'b0; dmem_req_i = 1'b0; dmem_we_i = 1'b0; mem_ack_i = 1'b1;
    imem_addr_i = '0; dmem_addr_i = '0; dmem_wdata_i = '0; mem_rdata_i = 32'hBEEF;
    model_reset();
    #3 check_outputs();
    @(negedge clk_i) arst_ni = 1'b1;
    repeat (400) step(30, 30, 35, 1'b1);
    repeat (60) step(100, 100, 50, 1'b0);
    repeat (200) step(20, 20, 100, 1'b0);
    n = 0;
    while (owner != 2 && n < 50) begin step(0, 100, 0, 1'b0); n++; end
    chk("reach_gnt_d", owner, 2);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #2 arst_ni = 1'b0;
    model_reset();
    #1 check_outputs();
    imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i) arst_ni = 1'b1;
    repeat (300) step(30, 30, 35, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter that lets the processor's instruction-fetch and data-access interfaces share a single memory port. It sits between the processor core (`imem_*` / `dmem_*` buses) and one memory slave. It serialises requests through a small grant FSM, registers the memory-side command, and routes the acknowledge and read data back to the winning requester. Arbitration is fixed-priority by default; round-robin is a compile-time option.

## Interface
- `ADDR_WIDTH`, default `simple_processor_pkg::ADDR_WIDTH`: address bus width on all three ports.
- `DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH`: data bus width on all three ports.

- `clk_i`  in  1  global clock; all state updates on its rising edge.
- `arst_ni`  in  1  asynchronous, active-low reset.
- `imem_req_i`  in  1  instruction request; held high until `imem_ack_o`.
- `imem_addr_i`  in  ADDR_WIDTH  instruction address; stable while `imem_req_i` is high.
- `imem_rdata_o`  out  DATA_WIDTH  instruction read data; valid only when `imem_ack_o` is high.
- `imem_ack_o`  out  1  instruction transaction complete.
- `dmem_req_i`  in  1  data request; held high until `dmem_ack_o`.
- `dmem_we_i`  in  1  data write enable (1 = write).
- `dmem_addr_i`  in  ADDR_WIDTH  data address.
- `dmem_wdata_i`  in  DATA_WIDTH  write data.
- `dmem_rdata_o`  out  DATA_WIDTH  data read data; valid only when `dmem_ack_o` is high.
- `dmem_ack_o`  out  1  data transaction complete.
- `mem_req_o`  out  1  request to the shared memory (registered).
- `mem_we_o`  out  1  write enable to memory (registered).
- `mem_addr_o`  out  ADDR_WIDTH  memory address (registered).
- `mem_wdata_o`  out  DATA_WIDTH  memory write data (registered).
- `mem_rdata_i`  in  DATA_WIDTH  memory read data; valid when `mem_ack_i` is high.
- `mem_ack_i`  in  1  memory transaction complete.
- `grant_o`  out  2  current owner: `2'b00` none, `2'b01` instruction, `2'b10` data.

## Operation
- FSM states: `IDLE`, `GNT_I`, `GNT_D`.
- **`IDLE`:**
  - With no request pending, stay in `IDLE`.
  - With a request pending, pick a winner, latch the winner's address, write enable and write data into the `mem_*` registers, set `mem_req_o` = 1, and move to `GNT_I` or `GNT_D`.
  - An instruction winner always gets `mem_we_o` = 0 and `mem_wdata_o` = 0.
- **`GNT_x`:**
  - `mem_*` registers hold their values until `mem_ack_i` arrives.
  - On `mem_ack_i`, the matching `*_ack_o` is driven high combinationally in the same cycle.
  - `*_rdata_o` is driven from `mem_rdata_i` in that cycle.
  - Next state is `IDLE`, with `mem_req_o`/`mem_we_o` cleared.
- **Arbitration with both requests pending:**
  - Default: data wins (fixed priority).
  - Round-robin: see Configuration.
- **Read-data routing:** the non-owner's ack is always 0, and its rdata is driven to 0.
- **`grant_o`:** reflects the FSM state.
- **Reset values:** state `IDLE`; `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` = 0; `imem_ack_o`, `dmem_ack_o` = 0; `grant_o` = 0; round-robin pointer = last-granted instruction.
- **Boundary conditions:**
  - `mem_ack_i` in `IDLE` is ignored; no ack is forwarded.
  - A requester dropping its request mid-transaction is a protocol violation. The arbiter still completes the memory transaction, and the ack is still pulsed.
  - A request that arrives in an ack cycle is not considered until the following `IDLE` cycle.
  - Assertion of `arst_ni` mid-transaction forces all outputs to their reset values immediately. The in-flight transaction is abandoned without an ack.

## Timing
- Request sampled in `IDLE` at edge N → `mem_req_o` high after edge N.
- The memory may ack in the first cycle `mem_req_o` is high (zero wait states).
- Minimum latency from requester `req` to `ack` is 1 cycle, i.e. the ack is seen in the cycle after `req` is first seen.
- Every transaction is followed by one mandatory `IDLE` cycle. Peak throughput is one transaction per 2 cycles.
- No combinational path from any `*_req_i` to `mem_*_o`.
- Combinational paths exist from `mem_ack_i`/`mem_rdata_i` to `*_ack_o`/`*_rdata_o`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - **Defined:** a 1-bit last-granted pointer is updated on each grant. On a tie, the requester not granted last wins. The reset pointer is "instruction", so the first tie goes to data.
  - **Undefined:** the pointer is not implemented and data always wins ties. Instruction fetch can be starved by continuous data requests.

## Test plan
- Single read: `imem_req_i`=1, `imem_addr_i`=0x10; memory acks in the first cycle with 0xBEEF → `mem_addr_o`=0x10 and `mem_we_o`=0 after 1 edge; `imem_ack_o`=1 and `imem_rdata_o`=0xBEEF in the ack cycle; `dmem_ack_o`=0.
- Data write with 3 wait states: `dmem_we_i`=1, addr 0x22, wdata 0x5A → `mem_*` stable for 4 cycles; `dmem_ack_o` pulses once; then 1 `IDLE` cycle.
- Simultaneous requests held for 4 transactions:
  - Fixed priority: grants D,D,D,D.
  - `MEM_ARB_ROUND_ROBIN_EN`: grants D,I,D,I.
- Spurious `mem_ack_i` in `IDLE` → no `*_ack_o` and no state change.
- `arst_ni` low while in `GNT_D` → `mem_req_o`=0, `grant_o`=0 and acks 0 immediately; after release the FSM is in `IDLE` and a new request is served normally.
